// File: rtl/wb_stage_pkg.sv
// wb_pkg: shared definitions for the CowCat32 write-back stage.
//   - din_sel encodings (DIN_CSR, DIN_LINK, DIN_ALU, DIN_LOAD)
//   - load funct3 codes
//   - write-back FSM state type
package wb_pkg;

  localparam logic [1:0] DIN_CSR  = 2'd0;
  localparam logic [1:0] DIN_LINK = 2'd1;
  localparam logic [1:0] DIN_ALU  = 2'd2;
  localparam logic [1:0] DIN_LOAD = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_stage_load_trim.sv
// load_trim: combinational lane select and sign/zero extension of load data.
// Ports:
//   funct3_i  load type (LB/LH/LW/LD/LBU/LHU/LWU)
//   off_i     byte offset of the load address within the XLEN word
//   rdata_i   aligned load word from memory
//   result_o  trimmed, extended XLEN result (0 for unsupported codes)
module load_trim
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int OFFW = $clog2(XLEN / 8),
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic [2:0]      funct3_i,
  input  logic [OFFW-1:0] off_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] result_o
);

  logic [SHW-1:0] bsh;
  logic [SHW-1:0] hsh;
  logic [SHW-1:0] wsh;
  logic [7:0]     b8;
  logic [15:0]    h16;
  logic [31:0]    w32;

  always_comb begin
    // Byte shift uses the full offset; halfword ignores offset[0];
    // word slot only exists on a 64-bit datapath.
    bsh = {off_i, 3'b000};
    hsh = {off_i[OFFW-1:1], 4'b0000};
    if (XLEN == 64) wsh = SHW'({off_i[OFFW-1], 5'b00000});
    else            wsh = '0;

    b8  = 8'(rdata_i >> bsh);
    h16 = 16'(rdata_i >> hsh);
    w32 = 32'(rdata_i >> wsh);

    result_o = '0;
    case (funct3_i)
      F3_LB:  result_o = XLEN'($signed(b8));
      F3_LH:  result_o = XLEN'($signed(h16));
      F3_LW:  result_o = XLEN'($signed(w32));
      F3_LBU: result_o = XLEN'(b8);
      F3_LHU: result_o = XLEN'(h16);
      F3_LWU: if (XLEN == 64) result_o = XLEN'(w32);
      F3_LD:  if (XLEN == 64) result_o = rdata_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: registered write-back stage for the CowCat32 core.
// Selects register-file write data (CSR / pc+4 / ALU / trimmed load), waits
// for load responses with a bounded timeout and issues a one-cycle write.
// Optional feature: define WB_CSR_EN to let din_sel 0 write csr_rdata.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    MEM-stage handshake (in_ready = state is IDLE)
//   din_sel               data source: 0 CSR, 1 link, 2 ALU, 3 load
//   pc, alu_out, csr_rdata  candidate write data sources
//   rd_we_in, rd_addr_in  destination write enable / index
//   ld_funct3, ld_addr_lo load type and byte offset
//   mem_rvalid, mem_rdata load response
//   rf_we, rf_waddr, rf_wdata  register-file write port (1-cycle strobe)
//   retire                one pulse per completed instruction
//   load_err              one pulse per abandoned (timed-out) load
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int REGW         = 5,
  parameter int LOAD_TIMEOUT = 15,
  localparam int OFFW = $clog2(XLEN / 8)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      din_sel,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic            rd_we_in,
  input  logic [REGW-1:0] rd_addr_in,
  input  logic [2:0]      ld_funct3,
  input  logic [OFFW-1:0] ld_addr_lo,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_we,
  output logic [REGW-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            retire,
  output logic            load_err
);

  localparam int CW = $clog2(LOAD_TIMEOUT + 1);

  wb_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ld_we_q, ld_we_d;
  logic [REGW-1:0] ld_rd_q, ld_rd_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [OFFW-1:0] ld_off_q, ld_off_d;

  logic            rf_we_q, rf_we_d;
  logic [REGW-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            retire_q, retire_d;
  logic            load_err_q, load_err_d;

  logic [XLEN-1:0] trim_data;
  logic [XLEN-1:0] nl_data;
  logic            nl_src_ok;

  load_trim #(.XLEN(XLEN)) u_load_trim (
    .funct3_i (ld_f3_q),
    .off_i    (ld_off_q),
    .rdata_i  (mem_rdata),
    .result_o (trim_data)
  );

  // Non-load result; nl_src_ok gates the write for a disabled CSR source.
  always_comb begin
    nl_data   = '0;
    nl_src_ok = 1'b1;
    case (din_sel)
      DIN_LINK: nl_data = pc + XLEN'(4);
      DIN_ALU:  nl_data = alu_out;
      DIN_CSR: begin
`ifdef WB_CSR_EN
        nl_data   = csr_rdata;
`else
        nl_src_ok = 1'b0;
`endif
      end
      default: nl_data = '0;
    endcase
  end

`ifndef WB_CSR_EN
  logic unused_csr;
  assign unused_csr = ^csr_rdata;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_we_d    = ld_we_q;
    ld_rd_d    = ld_rd_q;
    ld_f3_d    = ld_f3_q;
    ld_off_d   = ld_off_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    retire_d   = 1'b0;
    load_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (din_sel == DIN_LOAD) begin
            ld_we_d  = rd_we_in;
            ld_rd_d  = rd_addr_in;
            ld_f3_d  = ld_funct3;
            ld_off_d = ld_addr_lo;
            cnt_d    = '0;
            state_d  = WAIT_LOAD;
          end else begin
            rf_we_d    = rd_we_in && (rd_addr_in != '0) && nl_src_ok;
            rf_waddr_d = rd_addr_in;
            rf_wdata_d = nl_data;
            retire_d   = 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        // A response arriving on the final timeout cycle takes priority.
        if (mem_rvalid) begin
          rf_we_d    = ld_we_q && (ld_rd_q != '0);
          rf_waddr_d = ld_rd_q;
          rf_wdata_d = trim_data;
          retire_d   = 1'b1;
          state_d    = IDLE;
        end else if (cnt_q == CW'(LOAD_TIMEOUT - 1)) begin
          rf_waddr_d = ld_rd_q;
          rf_wdata_d = '0;
          retire_d   = 1'b1;
          load_err_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ld_we_q    <= 1'b0;
      ld_rd_q    <= '0;
      ld_f3_q    <= '0;
      ld_off_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      retire_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_we_q    <= ld_we_d;
      ld_rd_q    <= ld_rd_d;
      ld_f3_q    <= ld_f3_d;
      ld_off_q   <= ld_off_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      retire_q   <= retire_d;
      load_err_q <= load_err_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign retire   = retire_q;
  assign load_err = load_err_q;

endmodule
